// File: rtl/medidor_faixa_periodico.sv
// rtl/medidor_faixa_periodico.sv - periodic range meter with BCD window, dwell qualifier and ASCII report
//
// Purpose: periodically requests a packed-BCD measurement from the HC-SR04
// interface and registers it. The registered value is checked against an
// inclusive BCD window, the hit is qualified by a dwell counter, and a frame
// of DIGITS+2 ASCII characters is handed to a serial transmitter one at a time.
//
// Ports:
//   clock_i          system clock
//   reset_i          asynchronous active-high reset, clears all state
//   ligar_i          enable periodic operation
//   upperL_i         upper window limit, packed BCD, inclusive
//   lowerL_i         lower window limit, packed BCD, inclusive
//   medir_o          one-cycle measurement request
//   medida_i         packed-BCD result from the sensor interface
//   pronto_medida_i  one-cycle strobe, medida_i valid
//   tx_partida_o     one-cycle start to the serial transmitter
//   tx_dado_o        ASCII character, held while the character is in flight
//   tx_pronto_i      one-cycle strobe, character sent
//   dentro_o         registered measurement inside [lowerL_i, upperL_i]
//   acertou_o        dwell satisfied (level)
//   erro_timeout_o   last request timed out (sticky until next success)
//   db_medida_o      registered measurement
//   db_estado_o      FSM state code

module medidor_faixa_periodico #(
  parameter int         DIGITS         = 3,
  parameter int         PERIOD_CYCLES  = 12_500_000,
  parameter int         DWELL_CYCLES   = 150_000_000,
  parameter int         TIMEOUT_CYCLES = 1_500_000,
  parameter logic [6:0] TERM           = 7'h23
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  ligar_i,
  input  logic [4*DIGITS-1:0]   upperL_i,
  input  logic [4*DIGITS-1:0]   lowerL_i,
  output logic                  medir_o,
  input  logic [4*DIGITS-1:0]   medida_i,
  input  logic                  pronto_medida_i,
  output logic                  tx_partida_o,
  output logic [6:0]            tx_dado_o,
  input  logic                  tx_pronto_i,
  output logic                  dentro_o,
  output logic                  acertou_o,
  output logic                  erro_timeout_o,
  output logic [4*DIGITS-1:0]   db_medida_o,
  output logic [3:0]            db_estado_o
);

  localparam int W   = 4 * DIGITS;
  localparam int PW  = (PERIOD_CYCLES  > 1) ? $clog2(PERIOD_CYCLES)  : 1;
  localparam int DWW = (DWELL_CYCLES   > 1) ? $clog2(DWELL_CYCLES)   : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IW  = $clog2(DIGITS + 2);

  localparam logic [PW-1:0]  PER_MAX  = PW'(PERIOD_CYCLES - 1);
  localparam logic [DWW-1:0] DW_MAX   = DWW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]  IDX_STAT = IW'(DIGITS);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS + 1);

  localparam logic [6:0] CH_ERRO   = 7'h45;  // 'E'
  localparam logic [6:0] CH_DENTRO = 7'h44;  // 'D'
  localparam logic [6:0] CH_FORA   = 7'h46;  // 'F'

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    ESPERA    = 4'd1,
    MEDE      = 4'd2,
    AGUARDA   = 4'd3,
    REGISTRA  = 4'd4,
    TRANSMITE = 4'd5,
    ESPERA_TX = 4'd6,
    PROX_CHAR = 4'd7
  } estado_t;

  estado_t        state_q,  state_d;
  logic [W-1:0]   medida_q, medida_d;
  logic           erro_q,   erro_d;
  logic [TW-1:0]  tmo_q,    tmo_d;
  logic [PW-1:0]  per_q,    per_d;
  logic [DWW-1:0] dwell_q,  dwell_d;
  logic [IW-1:0]  idx_q,    idx_d;

  logic           dentro;
  logic [3:0]     digit;
  logic [6:0]     status_char;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= INICIAL;
      medida_q <= '0;
      erro_q   <= 1'b0;
      tmo_q    <= '0;
      per_q    <= '0;
      dwell_q  <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      medida_q <= medida_d;
      erro_q   <= erro_d;
      tmo_q    <= tmo_d;
      per_q    <= per_d;
      dwell_q  <= dwell_d;
      idx_q    <= idx_d;
    end
  end

  // Control FSM. The period counter only runs in ESPERA and is zero elsewhere,
  // so every entry into ESPERA starts a fresh period.
  always_comb begin
    state_d      = state_q;
    medida_d     = medida_q;
    erro_d       = erro_q;
    tmo_d        = tmo_q;
    per_d        = '0;
    idx_d        = idx_q;
    medir_o      = 1'b0;
    tx_partida_o = 1'b0;

    case (state_q)
      INICIAL: begin
        tmo_d = '0;
        idx_d = '0;
        if (ligar_i) state_d = MEDE;
      end
      ESPERA: begin
        if (!ligar_i) begin
          state_d = INICIAL;
        end else if (per_q == PER_MAX) begin
          state_d = MEDE;
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      MEDE: begin
        medir_o = 1'b1;
        tmo_d   = '0;
        state_d = AGUARDA;
      end
      AGUARDA: begin
        // A strobe arriving on the expiry cycle wins over the timeout.
        if (pronto_medida_i) begin
          medida_d = medida_i;
          erro_d   = 1'b0;
          state_d  = REGISTRA;
        end else if (tmo_q == TMO_MAX) begin
          erro_d  = 1'b1;
          state_d = REGISTRA;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      REGISTRA: begin
        idx_d   = '0;
        state_d = TRANSMITE;
      end
      TRANSMITE: begin
        tx_partida_o = 1'b1;
        state_d      = ESPERA_TX;
      end
      ESPERA_TX: begin
        if (tx_pronto_i) state_d = PROX_CHAR;
      end
      PROX_CHAR: begin
        // ligar is only sampled here, so a drop never truncates a frame.
        if (idx_q == IDX_LAST) begin
          state_d = ligar_i ? ESPERA : INICIAL;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = TRANSMITE;
        end
      end
      default: state_d = INICIAL;
    endcase
  end

  // Packed BCD with valid digits orders the same as its unsigned binary value.
  assign dentro = (lowerL_i <= medida_q) && (medida_q <= upperL_i) && !erro_q;

  // Dwell counter saturates; any miss or disable restarts it from zero.
  always_comb begin
    dwell_d = '0;
    if (state_q != INICIAL && dentro && ligar_i) begin
      dwell_d = (dwell_q == DW_MAX) ? dwell_q : dwell_q + 1'b1;
    end
  end

  // Digit selected by the character index, most significant digit first.
  always_comb begin
    digit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) digit = medida_q[4*(DIGITS-1-i) +: 4];
    end
  end

  always_comb begin
    if (erro_q)      status_char = CH_ERRO;
    else if (dentro) status_char = CH_DENTRO;
    else             status_char = CH_FORA;
  end

  always_comb begin
    tx_dado_o = 7'h00;
    if (state_q == TRANSMITE || state_q == ESPERA_TX) begin
      if (idx_q < IDX_STAT)       tx_dado_o = {3'b011, digit};
      else if (idx_q == IDX_STAT) tx_dado_o = status_char;
      else                        tx_dado_o = TERM;
    end
  end

  assign dentro_o       = dentro;
  assign acertou_o      = (dwell_q == DW_MAX) && dentro && ligar_i;
  assign erro_timeout_o = erro_q;
  assign db_medida_o    = medida_q;
  assign db_estado_o    = state_q;

endmodule

// File: tb/tb_medidor_faixa_periodico.sv
// tb/tb_medidor_faixa_periodico.sv - directed self-checking bench for medidor_faixa_periodico
//
// Purpose: drives the range meter with a sensor model (reply 3 cycles after
// medir) and a transmitter model (tx_pronto 5 cycles after tx_partida), and
// checks reset, framing, window, dwell, timeout, period and ligar handling.

module tb_medidor_faixa_periodico;

  localparam int DIG = 3;
  localparam int PER = 100;
  localparam int DW  = 50;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        ligar;
  logic [11:0] upper_l, lower_l;
  logic        medir;
  logic [11:0] medida;
  logic        pronto;
  logic        tx_partida;
  logic [6:0]  tx_dado;
  logic        tx_pronto;
  logic        dentro, acertou, erro;
  logic [11:0] db_medida;
  logic [3:0]  db_estado;

  medidor_faixa_periodico #(
    .DIGITS(DIG), .PERIOD_CYCLES(PER), .DWELL_CYCLES(DW),
    .TIMEOUT_CYCLES(TMO), .TERM(7'h23)
  ) dut (
    .clock_i(clk), .reset_i(rst), .ligar_i(ligar),
    .upperL_i(upper_l), .lowerL_i(lower_l),
    .medir_o(medir), .medida_i(medida), .pronto_medida_i(pronto),
    .tx_partida_o(tx_partida), .tx_dado_o(tx_dado), .tx_pronto_i(tx_pronto),
    .dentro_o(dentro), .acertou_o(acertou), .erro_timeout_o(erro),
    .db_medida_o(db_medida), .db_estado_o(db_estado)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Sensor model
  int          medir_cnt  = 0;
  int          medir_cyc  = 0;
  int          pronto_cyc = 0;
  bit          sensor_on  = 1'b1;
  logic [11:0] sensor_val = 12'h000;

  initial begin
    pronto = 1'b0;
    medida = 12'h000;
    forever begin
      @(posedge clk); #1;
      if (medir === 1'b1) begin
        medir_cnt++;
        medir_cyc = cyc;
        if (sensor_on) begin
          repeat (3) @(posedge clk);
          #1 pronto = 1'b1;
          medida = sensor_val;
          pronto_cyc = cyc;
          @(posedge clk); #1 pronto = 1'b0;
        end
      end
    end
  end

  // Transmitter model
  logic [6:0] chars[$];
  int         part_cyc[$];
  int         txp_cyc = 0;

  initial begin
    tx_pronto = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_partida === 1'b1) begin
        chars.push_back(tx_dado);
        part_cyc.push_back(cyc);
        repeat (5) @(posedge clk);
        #1 tx_pronto = 1'b1;
        txp_cyc = cyc;
        @(posedge clk); #1 tx_pronto = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic clear_chars();
    chars.delete();
    part_cyc.delete();
  endtask

  task automatic wait_chars(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      step();
      if (chars.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_medir(input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (medir_cnt > n0) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ligar = 1'b0; lower_l = 12'h100; upper_l = 12'h200;
    repeat (3) step();
    n_chk++; if (medir !== 1'b0) begin n_fail++; $display("FAIL reset_medir got %b want 0", medir); end
    n_chk++; if (tx_partida !== 1'b0) begin n_fail++; $display("FAIL reset_partida got %b want 0", tx_partida); end
    n_chk++; if (tx_dado !== 7'h00) begin n_fail++; $display("FAIL reset_dado got %h want 00", tx_dado); end
    n_chk++; if (dentro !== 1'b0 || acertou !== 1'b0 || erro !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b%b want 000", dentro, acertou, erro); end
    n_chk++; if (db_medida !== 12'h000) begin n_fail++; $display("FAIL reset_medida got %h want 000", db_medida); end
    n_chk++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_estado got %0d want 0", db_estado); end
    rst = 1'b0;
    repeat (2) step();
    n_chk++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL idle_estado got %0d want 0", db_estado); end
  endtask

  task automatic test_measure();
    logic [6:0] exp_c[5];
    bit ok;
    int c, n0;
    exp_c = '{7'h31, 7'h32, 7'h33, 7'h44, 7'h23};
    sensor_on = 1'b1; sensor_val = 12'h123;
    clear_chars();
    n0 = medir_cnt;
    c = cyc;
    ligar = 1'b1;
    wait_medir(n0, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL measure_medir timeout got none want pulse"); end
    n_chk++; if (medir_cyc !== c + 1) begin n_fail++; $display("FAIL medir_latency got %0d want %0d", medir_cyc, c + 1); end
    wait_chars(5, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL measure_frame timeout got %0d chars want 5", chars.size()); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        n_chk++; if (chars[i] !== exp_c[i]) begin n_fail++; $display("FAIL measure_char%0d got %h want %h", i, chars[i], exp_c[i]); end
      end
      n_chk++; if (part_cyc[0] !== pronto_cyc + 2) begin n_fail++; $display("FAIL first_partida got %0d want %0d", part_cyc[0], pronto_cyc + 2); end
      n_chk++; if (part_cyc[1] - part_cyc[0] !== 7) begin n_fail++; $display("FAIL char_spacing got %0d want 7", part_cyc[1] - part_cyc[0]); end
    end
    n_chk++; if (db_medida !== 12'h123) begin n_fail++; $display("FAIL measure_medida got %h want 123", db_medida); end
    n_chk++; if (dentro !== 1'b1) begin n_fail++; $display("FAIL measure_dentro got %b want 1", dentro); end
  endtask

  task automatic test_dwell();
    logic [6:0] exp_c[5];
    bit ok;
    logic prev;
    int d_rise;
    exp_c = '{7'h32, 7'h35, 7'h30, 7'h46, 7'h23};
    d_rise = pronto_cyc + 1;
    for (int i = 0; i < 300 && acertou !== 1'b1; i++) step();
    n_chk++; if (acertou !== 1'b1) begin n_fail++; $display("FAIL acertou_rise got 0 want 1"); end
    n_chk++; if (cyc - d_rise !== DW - 1) begin n_fail++; $display("FAIL acertou_delay got %0d want %0d", cyc - d_rise, DW - 1); end
    n_chk++; if (tx_dado !== 7'h00 || db_estado !== 4'd1) begin n_fail++; $display("FAIL espera_idle got dado=%h estado=%0d want 00/1", tx_dado, db_estado); end
    sensor_val = 12'h250;
    prev = acertou;
    for (int i = 0; i < 300; i++) begin
      if (dentro !== 1'b1) break;
      prev = acertou;
      step();
    end
    n_chk++; if (dentro !== 1'b0) begin n_fail++; $display("FAIL dwell_dentro_fall got %b want 0", dentro); end
    n_chk++; if (acertou !== 1'b0 || prev !== 1'b1) begin n_fail++; $display("FAIL acertou_fall got now=%b before=%b want 0/1", acertou, prev); end
    n_chk++; if (cyc !== pronto_cyc + 1) begin n_fail++; $display("FAIL dentro_fall_cycle got %0d want %0d", cyc, pronto_cyc + 1); end
    clear_chars();
    wait_chars(5, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL dwell_frame timeout got %0d chars want 5", chars.size()); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        n_chk++; if (chars[i] !== exp_c[i]) begin n_fail++; $display("FAIL dwell_char%0d got %h want %h", i, chars[i], exp_c[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] exp_e[5];
    logic [6:0] exp_d[5];
    bit ok;
    int m, n0;
    exp_e = '{7'h32, 7'h35, 7'h30, 7'h45, 7'h23};
    exp_d = '{7'h31, 7'h35, 7'h30, 7'h44, 7'h23};
    sensor_on = 1'b0;
    n0 = medir_cnt;
    wait_medir(n0, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL timeout_medir timeout got none want pulse"); end
    m = medir_cyc;
    for (int i = 0; i < 100 && cyc < m + TMO; i++) step();
    n_chk++; if (erro !== 1'b0) begin n_fail++; $display("FAIL erro_early got %b want 0 at cycle %0d", erro, cyc - m); end
    step();
    n_chk++; if (erro !== 1'b1) begin n_fail++; $display("FAIL erro_set got %b want 1 at cycle %0d", erro, cyc - m); end
    clear_chars();
    wait_chars(5, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL timeout_frame timeout got %0d chars want 5", chars.size()); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        n_chk++; if (chars[i] !== exp_e[i]) begin n_fail++; $display("FAIL timeout_char%0d got %h want %h", i, chars[i], exp_e[i]); end
      end
    end
    n_chk++; if (db_medida !== 12'h250 || dentro !== 1'b0) begin n_fail++; $display("FAIL timeout_hold got %h/%b want 250/0", db_medida, dentro); end
    sensor_on = 1'b1; sensor_val = 12'h150;
    clear_chars();
    wait_chars(5, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL recover_frame timeout got %0d chars want 5", chars.size()); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        n_chk++; if (chars[i] !== exp_d[i]) begin n_fail++; $display("FAIL recover_char%0d got %h want %h", i, chars[i], exp_d[i]); end
      end
    end
    n_chk++; if (erro !== 1'b0 || dentro !== 1'b1) begin n_fail++; $display("FAIL recover_flags got erro=%b dentro=%b want 0/1", erro, dentro); end
  endtask

  task automatic test_boundary();
    logic [11:0] vals[5];
    logic [11:0] los[5];
    logic [11:0] his[5];
    logic        exp_in[5];
    bit ok;
    vals   = '{12'h100, 12'h200, 12'h099, 12'h201, 12'h150};
    los    = '{12'h100, 12'h100, 12'h100, 12'h100, 12'h300};
    his    = '{12'h200, 12'h200, 12'h200, 12'h200, 12'h100};
    exp_in = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      sensor_val = vals[k]; lower_l = los[k]; upper_l = his[k];
      clear_chars();
      wait_chars(5, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL bound%0d_frame timeout got %0d chars want 5", k, chars.size()); end
      n_chk++; if (db_medida !== vals[k]) begin n_fail++; $display("FAIL bound%0d_medida got %h want %h", k, db_medida, vals[k]); end
      n_chk++; if (dentro !== exp_in[k]) begin n_fail++; $display("FAIL bound%0d_dentro got %b want %b", k, dentro, exp_in[k]); end
      if (ok) begin
        n_chk++; if (chars[3] !== (exp_in[k] ? 7'h44 : 7'h46)) begin n_fail++; $display("FAIL bound%0d_status got %h want %h", k, chars[3], exp_in[k] ? 7'h44 : 7'h46); end
      end
    end
    lower_l = 12'h100; upper_l = 12'h200;
  endtask

  task automatic test_ligar_drop();
    bit ok;
    int a, b, n0, n1;
    n0 = medir_cnt;
    wait_medir(n0, ok);
    a = medir_cyc;
    wait_medir(n0 + 1, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL period_medir timeout got none want pulse"); end
    b = medir_cyc;
    n_chk++; if (b !== txp_cyc + PER + 2) begin n_fail++; $display("FAIL period_rule got %0d want %0d", b, txp_cyc + PER + 2); end
    n_chk++; if (b - a !== 140) begin n_fail++; $display("FAIL period_spacing got %0d want 140", b - a); end
    clear_chars();
    wait_chars(3, ok);
    ligar = 1'b0;
    wait_chars(5, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL drop_frame timeout got %0d chars want 5", chars.size()); end
    n1 = medir_cnt;
    repeat (10) step();
    n_chk++; if (db_estado !== 4'd0 || tx_dado !== 7'h00) begin n_fail++; $display("FAIL drop_inicial got estado=%0d dado=%h want 0/00", db_estado, tx_dado); end
    repeat (300) step();
    n_chk++; if (medir_cnt !== n1 || chars.size() !== 5) begin n_fail++; $display("FAIL drop_quiet got medir=%0d chars=%0d want %0d/5", medir_cnt, chars.size(), n1); end
    if (ok) begin
      n_chk++; if (chars[4] !== 7'h23) begin n_fail++; $display("FAIL drop_term got %h want 23", chars[4]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n0, r;
    n0 = medir_cnt;
    ligar = 1'b1;
    wait_medir(n0, ok);
    clear_chars();
    wait_chars(2, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL midreset_frame timeout got %0d chars want 2", chars.size()); end
    rst = 1'b1;
    step();
    n_chk++; if (medir !== 1'b0 || tx_partida !== 1'b0 || tx_dado !== 7'h00) begin n_fail++; $display("FAIL midreset_outs got %b%b %h want 00 00", medir, tx_partida, tx_dado); end
    n_chk++; if (dentro !== 1'b0 || acertou !== 1'b0 || erro !== 1'b0 || db_medida !== 12'h000) begin n_fail++; $display("FAIL midreset_state got %b%b%b %h want 000 000", dentro, acertou, erro, db_medida); end
    n_chk++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL midreset_estado got %0d want 0", db_estado); end
    repeat (2) step();
    n0 = medir_cnt;
    r = cyc;
    rst = 1'b0;
    wait_medir(n0, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL midreset_medir timeout got none want pulse"); end
    n_chk++; if (medir_cyc !== r + 1) begin n_fail++; $display("FAIL midreset_latency got %0d want %0d", medir_cyc, r + 1); end
  endtask

  initial begin
    rst = 1'b1; ligar = 1'b0; lower_l = 12'h100; upper_l = 12'h200;
    test_reset();
    test_measure();
    test_dwell();
    test_timeout();
    test_boundary();
    test_ligar_drop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
